alu_exec_unit: RTL and testbench

//  Execution-stage ALU; consumes the 4-bit operation code from alu_control plus two operands.

---
 rtl/alu_exec_unit_pkg.sv | 24 ++
 rtl/alu_exec_unit_if.sv | 28 ++
 rtl/alu_exec_unit_iter_muldiv.sv | 72 +++++++
 rtl/alu_exec_unit.sv | 125 ++++++++++++
 tb/tb_alu_exec_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared operation codes and FSM state encodings for the execution-stage ALU.
// The op codes match the values that alu_control emits.
package alu_exec_unit_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_MOVE = 4'b0100,
        OP_SWAP = 4'b0101,
        OP_OR   = 4'b0111,
        OP_ADDR = 4'b1000
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between the EX pipeline stage and the ALU.
// The master side issues operations and consumes results; the slave side is the ALU.
interface alu_exec_unit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             div_zero;
    logic             illegal_op;

    modport master (
        output in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result_lo, result_hi, zero, div_zero, illegal_op
    );

    modport slave (
        input  in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result_lo, result_hi, zero, div_zero, illegal_op
    );
endinterface

// File: rtl/alu_exec_unit_iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and divider (restoring), one bit per clock.
// done is asserted combinationally on the final step; res_lo/res_hi then carry the finished result.
module alu_iter_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    count;
    logic             div_q;
    // MUL: hi_q = running partial product, lo_q = multiplier shifting out / product low half.
    // DIV: hi_q = partial remainder, lo_q = dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0] lo_q, hi_q, b_q;
    logic [WIDTH-1:0] lo_nxt, hi_nxt;
    logic [WIDTH:0]   sum, rs, trial;

    assign sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rs    = {hi_q, lo_q[WIDTH-1]};
    assign trial = rs - {1'b0, b_q};

    always_comb begin
        if (div_q) begin
            if (!trial[WIDTH]) begin
                hi_nxt = trial[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = rs[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done   = step && (count == CW'(WIDTH - 1));
    assign res_lo = lo_nxt;
    assign res_hi = hi_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            lo_q  <= a;
            hi_q  <= '0;
            b_q   <= b;
            div_q <= is_div;
        end else if (step) begin
            lo_q  <= lo_nxt;
            hi_q  <= hi_nxt;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle logic/add ops, iterative MUL/DIV, valid/ready on both sides.
// Result and flag registers are written together and held while the consumer stalls.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    state_e           state, state_nxt;
    logic             in_ready, accept, start, is_div, step, done, wr_en;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [WIDTH-1:0] lo_q, hi_q, lo_nxt, hi_nxt;
    logic             out_valid_q, zero_q, div_zero_q, illegal_q;
    logic             div_zero_nxt, illegal_nxt;

    assign in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign step     = (state != ST_IDLE);

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .is_div (is_div),
        .step   (step),
        .a      (bus.src_a),
        .b      (bus.src_b),
        .done   (done),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    always_comb begin
        state_nxt    = state;
        start        = 1'b0;
        is_div       = 1'b0;
        wr_en        = 1'b0;
        lo_nxt       = '0;
        hi_nxt       = '0;
        div_zero_nxt = 1'b0;
        illegal_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    wr_en = 1'b1;
                    case (bus.op)
                        OP_ADD, OP_ADDR: lo_nxt = bus.src_a + bus.src_b;
                        OP_SUB:          lo_nxt = bus.src_a - bus.src_b;
                        OP_MOVE:         lo_nxt = bus.src_b;
                        OP_OR:           lo_nxt = bus.src_a | bus.src_b;
                        OP_SWAP: begin
                            lo_nxt = bus.src_b;
                            hi_nxt = bus.src_a;
                        end
                        OP_MUL: begin
                            wr_en     = 1'b0;
                            start     = 1'b1;
                            state_nxt = ST_MUL;
                        end
                        OP_DIV: begin
                            // Divide by zero never enters the iterative path.
                            if (bus.src_b != '0) begin
                                wr_en     = 1'b0;
                                start     = 1'b1;
                                is_div    = 1'b1;
                                state_nxt = ST_DIV;
                            end else begin
                                lo_nxt       = '1;
                                hi_nxt       = bus.src_a;
                                div_zero_nxt = 1'b1;
                            end
                        end
                        default: illegal_nxt = 1'b1;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (done) begin
                    wr_en     = 1'b1;
                    lo_nxt    = md_lo;
                    hi_nxt    = md_hi;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            // A new write wins over the consumer draining the old result (back-to-back issue).
            if (wr_en) begin
                out_valid_q <= 1'b1;
                lo_q        <= lo_nxt;
                hi_q        <= hi_nxt;
                zero_q      <= (lo_nxt == '0);
                div_zero_q  <= div_zero_nxt;
                illegal_q   <= illegal_nxt;
            end else if (start || bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.result_lo  = lo_q;
    assign bus.result_hi  = hi_q;
    assign bus.zero       = zero_q;
    assign bus.div_zero   = div_zero_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit: expected results are queued at issue
// and compared field by field when the ALU hands the result to the consumer.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        zero;
        logic        dz;
        logic        ill;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    errors = 0;
    int    checks = 0;
    exp_t  sb[$];
    string sb_tag[$];
    logic  acc_seen;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] p;
        e = '0;
        case (op)
            4'b0000, 4'b1000: e.lo = a + b;
            4'b0001: e.lo = a - b;
            4'b0010: begin
                p    = 32'(a) * 32'(b);
                e.lo = p[15:0];
                e.hi = p[31:16];
            end
            4'b0011: begin
                if (b == 16'h0) begin
                    e.lo = 16'hFFFF;
                    e.hi = a;
                    e.dz = 1'b1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            4'b0100: e.lo = b;
            4'b0101: begin
                e.lo = b;
                e.hi = a;
            end
            4'b0111: e.lo = a | b;
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.lo == 16'h0);
        return e;
    endfunction

    // One clock: sample at the falling edge, pop/compare any result being handed over, advance.
    task automatic tick();
        exp_t  e;
        string t;
        @(negedge clk);
        acc_seen = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty: observed=unexpected result lo=%h expected=no result", bus.result_lo);
            end else begin
                e = sb.pop_front();
                t = sb_tag.pop_front();
                chk({t, ".lo"},   bus.result_lo,  e.lo);
                chk({t, ".hi"},   bus.result_hi,  e.hi);
                chk({t, ".zero"}, bus.zero,       e.zero);
                chk({t, ".dz"},   bus.div_zero,   e.dz);
                chk({t, ".ill"},  bus.illegal_op, e.ill);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, output int waited);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        sb.push_back(model(op, a, b));
        sb_tag.push_back(tag);
        waited   = 0;
        acc_seen = 1'b0;
        while (!acc_seen && waited < 64) begin
            tick();
            waited++;
        end
        if (!acc_seen) chk({tag, ".accept_timeout"}, 32'(waited), 32'(1));
        // Operands are scrambled after accept: the ALU must not rely on them being held.
        bus.in_valid = 1'b0;
        bus.op       = 4'($urandom);
        bus.src_a    = 16'($urandom);
        bus.src_b    = 16'($urandom);
    endtask

    // Single-cycle op: the result must be valid right after the accepting edge.
    task automatic send1(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int w;
        send(tag, op, a, b, w);
        chk({tag, ".latency"}, bus.out_valid, 1'b1);
    endtask

    // Iterative op: count cycles with in_ready low until the result appears.
    task automatic wait_iter(input string tag, input int exp_busy);
        int n = 0;
        int guard = 0;
        while (!bus.out_valid && guard < 64) begin
            if (!bus.in_ready) n++;
            tick();
            guard++;
        end
        chk({tag, ".busy_cycles"}, 32'(n), 32'(exp_busy));
    endtask

    initial begin
        int w;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 4'h0;
        bus.src_a     = 16'h0;
        bus.src_b     = 16'h0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", bus.out_valid,  1'b0);
        chk("rst.in_ready",  bus.in_ready,   1'b1);
        chk("rst.lo",        bus.result_lo,  16'h0);
        chk("rst.hi",        bus.result_hi,  16'h0);
        chk("rst.flags",     {bus.zero, bus.div_zero, bus.illegal_op}, 3'b000);
        rst_n = 1'b1;
        tick();

        // Single-cycle ops
        bus.out_ready = 1'b1;
        send1("add_wrap", 4'b0000, 16'hFFFF, 16'h0002);
        send1("sub_zero", 4'b0001, 16'h0005, 16'h0005);
        send1("sub_wrap", 4'b0001, 16'h0003, 16'h0005);
        send1("swap",     4'b0101, 16'h1234, 16'hABCD);
        send1("move",     4'b0100, 16'h5555, 16'h00F0);
        send1("addr",     4'b1000, 16'h1000, 16'h0024);
        tick();

        // Iterative multiply
        send("mul_a", 4'b0010, 16'h0300, 16'h0100, w);
        wait_iter("mul_a", 16);
        send("mul_max", 4'b0010, 16'hFFFF, 16'hFFFF, w);
        wait_iter("mul_max", 16);

        // Iterative divide and the divide-by-zero shortcut
        send("div_a", 4'b0011, 16'h0064, 16'h0007, w);
        wait_iter("div_a", 16);
        send("div_big", 4'b0011, 16'hFFFF, 16'h0001, w);
        wait_iter("div_big", 16);
        send("div_small", 4'b0011, 16'h0003, 16'h0009, w);
        wait_iter("div_small", 16);
        send1("div_zero", 4'b0011, 16'h1234, 16'h0000);
        send1("flag_clear", 4'b0000, 16'h0001, 16'h0001);
        tick();

        // Consumer stall holds the result and blocks new issue
        bus.out_ready = 1'b0;
        send1("hold_add", 4'b0000, 16'h0001, 16'h0002);
        for (int i = 0; i < 5; i++) begin
            chk("hold.out_valid", bus.out_valid, 1'b1);
            chk("hold.lo",        bus.result_lo, 16'h0003);
            chk("hold.in_ready",  bus.in_ready,  1'b0);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send("or_b2b", 4'b0111, 16'h00F0 << i, 16'h0003 + 16'(i), w);
            chk("or_b2b.rate",      32'(w), 32'(1));
            chk("or_b2b.out_valid", bus.out_valid, 1'b1);
        end
        tick();

        // Reset during an iterative multiply aborts it without a result
        send("mul_abort", 4'b0010, 16'h0011, 16'h0022, w);
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        sb.delete();
        sb_tag.delete();
        chk("abort.out_valid_in_rst", bus.out_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort.in_ready",  bus.in_ready,  1'b1);
        repeat (12) tick();
        chk("abort.no_result", bus.out_valid, 1'b0);
        chk("abort.lo",        bus.result_lo, 16'h0);

        // Undefined op codes
        send1("illegal_f", 4'b1111, 16'h0005, 16'h0006);
        send1("illegal_6", 4'b0110, 16'h0005, 16'h0006);
        send1("after_ill", 4'b0111, 16'h0000, 16'h0000);
        tick();
        tick();

        chk("sb.drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
